// File: rtl/guess_game_pkg.sv
// Shared encodings for the guessing-game round controller: result codes, FSM states, status LEDs.
package guess_game_pkg;

    localparam logic [1:0] CMP_NONE    = 2'b00;
    localparam logic [1:0] CMP_UP      = 2'b01;
    localparam logic [1:0] CMP_DOWN    = 2'b10;
    localparam logic [1:0] CMP_CORRECT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_PLAY,
        ST_CMP,
        ST_WIN,
        ST_LOSE
    } state_t;

    // game_status is one-hot {LOSE, WIN, PLAYING}
    localparam logic [2:0] GS_NONE    = 3'b000;
    localparam logic [2:0] GS_PLAYING = 3'b001;
    localparam logic [2:0] GS_WIN     = 3'b010;
    localparam logic [2:0] GS_LOSE    = 3'b100;

endpackage

// File: rtl/guess_round_sequencer_if.sv
// Player, random-generator and display signals of the round controller.
// HINT_RANGE_EN adds the range_lo/range_hi hint outputs.
interface guess_round_sequencer_if #(
    parameter int NUM_W = 7
);
    logic             start_game;
    logic             guess_trigger;
    logic [NUM_W-1:0] user_number;
    logic [NUM_W-1:0] rng_value;
    logic             rng_valid;
    logic             rng_req;
    logic [NUM_W-1:0] actual_number;
    logic [1:0]       comparison_result;
    logic [3:0]       attempts;
    logic [2:0]       game_status;
    logic             game_over;
`ifdef HINT_RANGE_EN
    logic [NUM_W-1:0] range_lo;
    logic [NUM_W-1:0] range_hi;
`endif

    modport master (
        output start_game, guess_trigger, user_number, rng_value, rng_valid,
        input  rng_req, actual_number, comparison_result, attempts, game_status, game_over
`ifdef HINT_RANGE_EN
        , input range_lo, range_hi
`endif
    );

    modport slave (
        input  start_game, guess_trigger, user_number, rng_value, rng_valid,
        output rng_req, actual_number, comparison_result, attempts, game_status, game_over
`ifdef HINT_RANGE_EN
        , output range_lo, range_hi
`endif
    );

endinterface

// File: rtl/guess_round_sequencer_edge_pulse.sv
// One-register rising-edge detector; pulse is combinational, same cycle as the rising input.
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic din_q;

    // Reset absorbs the current level so a button held through reset is not seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) din_q <= din;
        else       din_q <= din;
    end

    assign pulse = din & ~din_q;

endmodule

// File: rtl/guess_round_sequencer.sv
// Round controller: seeds a secret, scores guesses (result 2 cycles after the guess edge), declares win/loss.
// Optional HINT_RANGE_EN tracks a narrowing [range_lo, range_hi] window and rejects guesses outside it.
module guess_round_sequencer
    import guess_game_pkg::*;
#(
    parameter int NUM_W        = 7,
    parameter int MAX_VALUE    = 99,
    parameter int MAX_ATTEMPTS = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    guess_round_sequencer_if.slave  io
);

    localparam logic [NUM_W-1:0] MAX_V   = NUM_W'(MAX_VALUE);
    localparam logic [3:0]       MAX_ATT = 4'(MAX_ATTEMPTS);

    state_t           state, state_nxt;
    logic             start_evt, guess_evt;
    logic [NUM_W-1:0] secret_q, guess_q;
    logic [1:0]       result_q, cmp_res;
    logic [3:0]       attempts_q, attempts_inc;
    logic             rng_ok, guess_ok, restart;
    logic             rng_req;
    logic [2:0]       game_status;

    edge_pulse u_start_edge (.clk(clk), .reset(reset), .din(io.start_game),    .pulse(start_evt));
    edge_pulse u_guess_edge (.clk(clk), .reset(reset), .din(io.guess_trigger), .pulse(guess_evt));

    assign rng_ok  = io.rng_valid && (io.rng_value <= MAX_V);
    assign restart = start_evt && (state != ST_CMP);

`ifdef HINT_RANGE_EN
    logic [NUM_W-1:0] lo_q, hi_q;
    assign guess_ok    = (io.user_number <= MAX_V) && (io.user_number >= lo_q) && (io.user_number <= hi_q);
    assign io.range_lo = lo_q;
    assign io.range_hi = hi_q;
`else
    assign guess_ok = (io.user_number <= MAX_V);
`endif

    always_comb begin
        cmp_res = CMP_DOWN;
        if (guess_q == secret_q)     cmp_res = CMP_CORRECT;
        else if (guess_q < secret_q) cmp_res = CMP_UP;
        attempts_inc = (attempts_q >= MAX_ATT) ? MAX_ATT : attempts_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        rng_req     = 1'b0;
        game_status = GS_NONE;
        case (state)
            ST_IDLE: if (start_evt) state_nxt = ST_SEED;
            ST_SEED: begin
                rng_req = 1'b1;
                if (start_evt)   state_nxt = ST_SEED;
                else if (rng_ok) state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                game_status = GS_PLAYING;
                if (start_evt)                  state_nxt = ST_SEED;
                else if (guess_evt && guess_ok) state_nxt = ST_CMP;
            end
            ST_CMP: begin
                if (cmp_res == CMP_CORRECT)     state_nxt = ST_WIN;
                else if (attempts_inc == MAX_ATT) state_nxt = ST_LOSE;
                else                            state_nxt = ST_PLAY;
            end
            ST_WIN: begin
                game_status = GS_WIN;
                if (start_evt) state_nxt = ST_SEED;
            end
            ST_LOSE: begin
                game_status = GS_LOSE;
                if (start_evt) state_nxt = ST_SEED;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath; a restart outranks any guess or seed arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            secret_q   <= '0;
            guess_q    <= '0;
            result_q   <= CMP_NONE;
            attempts_q <= '0;
`ifdef HINT_RANGE_EN
            lo_q       <= '0;
            hi_q       <= MAX_V;
`endif
        end else if (restart) begin
            result_q   <= CMP_NONE;
            attempts_q <= '0;
`ifdef HINT_RANGE_EN
            lo_q       <= '0;
            hi_q       <= MAX_V;
`endif
        end else begin
            case (state)
                ST_SEED: if (rng_ok) secret_q <= io.rng_value;
                ST_PLAY: begin
                    if (guess_evt) begin
                        if (guess_ok) guess_q  <= io.user_number;
                        else          result_q <= CMP_NONE;
                    end
                end
                ST_CMP: begin
                    result_q   <= cmp_res;
                    attempts_q <= attempts_inc;
`ifdef HINT_RANGE_EN
                    // guess lies inside [lo, hi], so these updates can only narrow the window
                    if (cmp_res == CMP_UP)   lo_q <= guess_q + NUM_W'(1);
                    if (cmp_res == CMP_DOWN) hi_q <= guess_q - NUM_W'(1);
`endif
                end
                default: ;
            endcase
        end
    end

    assign io.rng_req           = rng_req;
    assign io.actual_number     = secret_q;
    assign io.comparison_result = result_q;
    assign io.attempts          = attempts_q;
    assign io.game_status       = game_status;
    assign io.game_over         = (state == ST_WIN) || (state == ST_LOSE);

endmodule
